// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a request-to-send,
// then clocks out one command byte on device-generated clock edges and checks the ACK.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQUEST   = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t          r_state, w_state;
  logic            r_clk_s1, r_clk_s2, r_clk_prev;
  logic            r_dat_s1, r_dat_s2;
  logic [IW-1:0]   r_inh_cnt, w_inh_cnt;
  logic [TW-1:0]   r_to_cnt, w_to_cnt;
  logic [3:0]      r_bit_cnt, w_bit_cnt;
  logic [9:0]      r_shift, w_shift;
  logic            r_err, w_err;
  logic            r_clk_oe, w_clk_oe;
  logic            r_dat_oe, w_dat_oe;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_error, w_error;
  logic            w_fall;
  logic            w_timeout;

  // Handshake: start is accepted only in IDLE; busy stays high until the cycle
  // done pulses, and a new start may be presented in that same done cycle.
  assign w_fall    = r_clk_prev & ~r_clk_s2;
  // Fires on the edge where the counter reaches TIMEOUT_CYCLES after release.
  assign w_timeout = (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state   = r_state;
    w_inh_cnt = r_inh_cnt;
    w_to_cnt  = r_to_cnt;
    w_bit_cnt = r_bit_cnt;
    w_shift   = r_shift;
    w_err     = r_err;
    w_clk_oe  = r_clk_oe;
    w_dat_oe  = r_dat_oe;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_error   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clk_oe = 1'b0;
        w_dat_oe = 1'b0;
        w_busy   = 1'b0;
        if (start) begin
          w_state   = S_INHIBIT;
          w_shift   = {1'b1, ~^data, data};
          w_inh_cnt = '0;
          w_to_cnt  = '0;
          w_bit_cnt = '0;
          w_err     = 1'b0;
          w_clk_oe  = 1'b1;
          w_dat_oe  = (INHIBIT_CYCLES == 1);
          w_busy    = 1'b1;
        end
      end
      S_INHIBIT: begin
        if (r_inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
          w_state  = S_REQUEST;
          w_clk_oe = 1'b0;
          w_dat_oe = 1'b1;
          w_to_cnt = '0;
        end else begin
          w_inh_cnt = r_inh_cnt + IW'(1);
          w_dat_oe  = (r_inh_cnt == IW'(INHIBIT_CYCLES - 2));
        end
      end
      S_REQUEST, S_SHIFT: begin
        if (w_fall) begin
          w_bit_cnt = r_bit_cnt + 4'd1;
          w_dat_oe  = ~r_shift[0];
          w_shift   = {1'b0, r_shift[9:1]};
          w_state   = (r_bit_cnt == 4'd9) ? S_ACK : S_SHIFT;
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_bit_cnt = 4'd11;
          w_err     = r_dat_s2;
          w_state   = S_WAIT_IDLE;
        end
      end
      S_WAIT_IDLE: begin
        if (r_clk_s2 && r_dat_s2) begin
          w_state  = S_IDLE;
          w_done   = 1'b1;
          w_error  = r_err;
          w_busy   = 1'b0;
          w_clk_oe = 1'b0;
          w_dat_oe = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    // Timeout overrides any bus activity seen in the same cycle.
    if (r_state == S_REQUEST || r_state == S_SHIFT ||
        r_state == S_ACK || r_state == S_WAIT_IDLE) begin
      w_to_cnt = r_to_cnt + TW'(1);
      if (w_timeout) begin
        w_state  = S_IDLE;
        w_clk_oe = 1'b0;
        w_dat_oe = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b1;
        w_error  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_err      <= 1'b0;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_dat;
      r_dat_s2   <= r_dat_s1;
      r_state    <= w_state;
      r_inh_cnt  <= w_inh_cnt;
      r_to_cnt   <= w_to_cnt;
      r_bit_cnt  <= w_bit_cnt;
      r_shift    <= w_shift;
      r_err      <= w_err;
      r_clk_oe   <= w_clk_oe;
      r_dat_oe   <= w_dat_oe;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_error    <= w_error;
    end
  end

  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign dbg_state  = r_state;

endmodule
